// File: rtl/noc_port_pkt_arbiter_pkg.sv
// Shared types and flit-field helpers for the NoC injection-port arbiter and fabric-side checkers.
package noc_arb_pkg;
  localparam int FLIT_MAX = 1024;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Field positions depend only on the flit width, so masks fold to constants.
  function automatic logic [FLIT_MAX-1:0] head_mask(input int w);
    logic [FLIT_MAX-1:0] one;
    one = {{(FLIT_MAX-1){1'b0}}, 1'b1};
    head_mask = one << (w - 2);
  endfunction

  function automatic logic [FLIT_MAX-1:0] eop_mask(input int w);
    logic [FLIT_MAX-1:0] one;
    one = {{(FLIT_MAX-1){1'b0}}, 1'b1};
    eop_mask = '0;
    for (int k = 0; k < 4; k++) eop_mask = eop_mask | (one << (w - 3 - k * (w / 4)));
  endfunction

  function automatic logic flit_is_head(input logic [FLIT_MAX-1:0] f, input int w);
    flit_is_head = |(f & head_mask(w));
  endfunction

  function automatic logic flit_has_eop(input logic [FLIT_MAX-1:0] f, input int w);
    flit_has_eop = |(f & eop_mask(w));
  endfunction
endpackage

// File: rtl/noc_port_pkt_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after the pointer, wrapping. Pure combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_j   = '0;
    for (int off = 0; off < N; off++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(off);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_j = w_sum[PW-1:0];
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end
endmodule

// File: rtl/noc_port_pkt_arbiter.sv
// Packet-aware round-robin arbiter sharing one NoC injection port among NUM_REQ flit sources.
// state  | meaning
// IDLE   | no open packet; heads compete round-robin, stray body flits are dropped
// LOCKED | owner holds the port until EOP or the length limit
module noc_port_pkt_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NOC_WIDTH     = 600,
  parameter int NUM_REQ       = 4,
  parameter int MAX_PKT_FLITS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NOC_WIDTH-1:0] i_data_in [0:NUM_REQ-1],
  input  logic [NUM_REQ-1:0]   i_valid_in,
  output logic [NUM_REQ-1:0]   i_ready_out,
  output logic [NOC_WIDTH-1:0] o_data_out,
  output logic                 o_valid_out,
  input  logic                 o_ready_in,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_err_proto,
  output logic                 o_err_len
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_PKT_FLITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PKT_FLITS);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  arb_state_t           r_state;
  logic [PW-1:0]        r_ptr, r_owner;
  logic [CW-1:0]        r_cnt;
  logic [NOC_WIDTH-1:0] r_data_out;
  logic                 r_valid_out, r_err_proto, r_err_len;

  logic [NUM_REQ-1:0]   w_head, w_eop, w_stray, w_pick_gnt;
  logic [PW-1:0]        w_pick_idx, w_src, w_src_next;
  logic                 w_pick_any, w_adv, w_acc, w_acc_head, w_acc_eop;
  logic [NOC_WIDTH-1:0] w_acc_data;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_head[i] = flit_is_head(FLIT_MAX'(i_data_in[i]), NOC_WIDTH);
      w_eop[i]  = flit_has_eop(FLIT_MAX'(i_data_in[i]), NOC_WIDTH);
    end
  end

  assign w_stray = i_valid_in & ~w_head;
  assign w_adv   = !r_valid_out || o_ready_in;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req (i_valid_in & w_head),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Grant and ready are combinational so a head is taken in the cycle it wins.
  always_comb begin
    i_ready_out = '0;
    o_grant     = '0;
    w_acc       = 1'b0;
    w_src       = r_owner;
    if (reset) begin
      if (r_state == IDLE) begin
        w_src       = w_pick_idx;
        w_acc       = w_pick_any && w_adv;
        i_ready_out = w_stray | (w_acc ? w_pick_gnt : '0);
        o_grant     = w_acc ? w_pick_gnt : '0;
      end else begin
        w_acc                = i_valid_in[r_owner] && w_adv;
        i_ready_out[r_owner] = w_adv;
        o_grant[r_owner]     = 1'b1;
      end
    end
  end

  assign w_acc_data = i_data_in[w_src];
  assign w_acc_head = w_head[w_src];
  assign w_acc_eop  = w_eop[w_src];
  assign w_src_next = (w_src == PTR_LAST) ? '0 : w_src + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_err_proto <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      if (w_adv) begin
        r_valid_out <= w_acc;
        if (w_acc) r_data_out <= w_acc_data;
      end
      case (r_state)
        IDLE: begin
          if (|w_stray) r_err_proto <= 1'b1;
          if (w_acc) begin
            if (w_acc_eop) begin
              r_ptr <= w_src_next;
            end else begin
              r_state <= LOCKED;
              r_owner <= w_src;
              r_cnt   <= CW'(1);
            end
          end
        end
        LOCKED: begin
          if (w_acc) begin
            if (w_acc_head) r_err_proto <= 1'b1;
            if (w_acc_eop) begin
              r_state <= IDLE;
              r_ptr   <= w_src_next;
              r_cnt   <= '0;
            end else if (r_cnt + 1'b1 == CNT_MAX) begin
              // Runaway packet: release the port, downstream sees it truncated.
              r_err_len <= 1'b1;
              r_state   <= IDLE;
              r_ptr     <= w_src_next;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_data_out  = r_data_out;
  assign o_valid_out = r_valid_out;
  assign o_err_proto = r_err_proto;
  assign o_err_len   = r_err_len;
endmodule
